// File: rtl/sgm_pkg.sv
// Shared definitions for the block-matching disparity path.
//   SGM_DISP_W / SGM_SAD_W / SGM_XW : default widths of disparity, SAD cost
//                                     and raster coordinates
//   sched_state_t                   : disparity-search scheduler states
//   min_upd()                       : running-minimum replace decision
package sgm_pkg;

    localparam int SGM_DISP_W = 4;
    localparam int SGM_SAD_W  = 10;
    localparam int SGM_XW     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } sched_state_t;

    // True when a returned cost should become the new best. The first
    // candidate always loads; afterwards only a strictly smaller cost wins,
    // so a tie keeps the lower disparity.
    function automatic logic min_upd(
        input logic                 first,
        input logic [SGM_SAD_W-1:0] cost,
        input logic [SGM_SAD_W-1:0] best
    );
        return first || (cost < best);
    endfunction

endpackage

// File: rtl/sad_disp_sched_raster_cnt.sv
// raster_cnt: raster x/y position of the next pixel to be handed off.
//   clk, rst   : clock, synchronous active-high reset
//   adv        : a pixel is handed off this cycle; step to the next position
//   x, y       : current raster position
//   frame_done : high in the cycle the last pixel of the frame is handed off
module raster_cnt
    import sgm_pkg::*;
#(
    parameter int FRAME_W = 8,
    parameter int FRAME_H = 8,
    parameter int XW      = SGM_XW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [XW-1:0] y,
    output logic          frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [XW-1:0] Y_LAST = XW'(FRAME_H - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + XW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign frame_done = adv && (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/sad_disp_sched.sv
// sad_disp_sched: per-pixel disparity search scheduler.
// For each accepted pixel, issues one SAD request per candidate disparity
// (limited by the left border and MAX_DISP), tracks the running minimum of
// the returned costs and presents the winner with its coordinates.
//   clk, rst                  : clock, synchronous active-high reset
//   pix_vld / pix_rdy         : next raster pixel window ready / accept
//   sad_req, sad_disp         : SAD request and its candidate disparity
//   sad_vld, sad_cost         : SAD result, returned in issue order
//   disp_vld / disp_rdy       : result handshake, result held until accepted
//   disp, disp_cost           : winning disparity and its cost
//   disp_x, disp_y            : coordinates of the result pixel
//   frame_done                : pulse on handoff of the last pixel of a frame
//   err                       : sticky, SAD result with nothing outstanding
//
// state | meaning
// IDLE  | waiting for a pixel, pix_rdy high
// ISSUE | one SAD request per cycle, d = 0 .. N-1
// DRAIN | all requests issued, waiting for the remaining results
// OUT   | result presented, waiting for disp_rdy
module sad_disp_sched
    import sgm_pkg::*;
#(
    parameter int MAX_DISP = 16,
    parameter int DISP_W   = SGM_DISP_W,
    parameter int SAD_W    = SGM_SAD_W,
    parameter int FRAME_W  = 8,
    parameter int FRAME_H  = 8,
    parameter int XW       = SGM_XW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_vld,
    output logic              pix_rdy,
    output logic              sad_req,
    output logic [DISP_W-1:0] sad_disp,
    input  logic              sad_vld,
    input  logic [SAD_W-1:0]  sad_cost,
    output logic              disp_vld,
    input  logic              disp_rdy,
    output logic [DISP_W-1:0] disp,
    output logic [SAD_W-1:0]  disp_cost,
    output logic [XW-1:0]     disp_x,
    output logic [XW-1:0]     disp_y,
    output logic              frame_done,
    output logic              err
);

    // Return counter runs 0..N with N up to 2^DISP_W, hence one extra bit.
    localparam int CW = DISP_W + 1;
    localparam logic [DISP_W-1:0] MAX_D = DISP_W'(MAX_DISP - 1);

    sched_state_t      state, state_nxt;
    logic [DISP_W-1:0] d;
    logic [DISP_W-1:0] last_d;     // N-1, fits DISP_W even when N = 2^DISP_W
    logic [DISP_W-1:0] best_disp;
    logic [SAD_W-1:0]  best_cost;
    logic [CW-1:0]     r;
    logic [CW-1:0]     n_cnt;
    logic [XW-1:0]     x, y;
    logic [XW-1:0]     pix_x, pix_y;
    logic              accept;
    logic              handoff;
    logic              searching;
    logic              sad_ok;
    logic              all_back;

    assign accept    = (state == IDLE) && pix_vld;
    assign handoff   = (state == OUT) && disp_rdy;
    assign searching = (state == ISSUE) || (state == DRAIN);
    assign n_cnt     = {1'b0, last_d} + CW'(1);
    assign sad_ok    = sad_vld && searching && (r != n_cnt);
    // The final result is recognised in the cycle it arrives so the winner
    // is presented on the very next cycle, even when it overlaps the last
    // request.
    assign all_back  = sad_ok && ((r + CW'(1)) == n_cnt);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pix_vld) state_nxt = ISSUE;
            ISSUE:   if (d == last_d) state_nxt = all_back ? OUT : DRAIN;
            DRAIN:   if (all_back) state_nxt = OUT;
            OUT:     if (disp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            d         <= '0;
            last_d    <= '0;
            r         <= '0;
            best_disp <= '0;
            best_cost <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Left border: no candidate may reach past column 0.
                last_d <= (int'(x) >= MAX_DISP - 1) ? MAX_D : DISP_W'(x);
                d      <= '0;
                r      <= '0;
                pix_x  <= x;
                pix_y  <= y;
            end
            if (state == ISSUE) begin
                d <= d + DISP_W'(1);
            end
            if (sad_ok) begin
                r <= r + CW'(1);
                if (min_upd(r == '0, sad_cost, best_cost)) begin
                    best_cost <= sad_cost;
                    best_disp <= r[DISP_W-1:0];
                end
            end
            if (sad_vld && !sad_ok) begin
                err <= 1'b1;
            end
        end
    end

    raster_cnt #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .XW      (XW)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .adv        (handoff),
        .x          (x),
        .y          (y),
        .frame_done (frame_done)
    );

    assign pix_rdy   = (state == IDLE);
    assign sad_req   = (state == ISSUE);
    assign sad_disp  = sad_req ? d : '0;
    assign disp_vld  = (state == OUT);
    assign disp      = best_disp;
    assign disp_cost = best_cost;
    assign disp_x    = pix_x;
    assign disp_y    = pix_y;

endmodule

// File: tb/tb_sad_disp_sched.sv
module tb_sad_disp_sched;

    localparam int DW = 4;
    localparam int SW = 10;
    localparam int XW = 3;

    typedef struct {
        int disp;
        int cost;
        int x;
        int y;
        int t_acc;
        int n;
        int lat;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          pix_vld, pix_rdy, sad_req, sad_vld, disp_vld, disp_rdy, frame_done, err;
    logic [DW-1:0] sad_disp, disp;
    logic [SW-1:0] sad_cost, disp_cost;
    logic [XW-1:0] disp_x, disp_y;

    logic          pix_vld4, pix_rdy4, sad_req4, sad_vld4, disp_vld4, frame_done4, err4;
    logic          disp_rdy4;
    logic [DW-1:0] sad_disp4, disp4;
    logic [SW-1:0] sad_cost4, disp_cost4;
    logic [XW-1:0] disp_x4, disp_y4;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   lat;
    int   req_cnt;
    int   fd_cnt = 0;
    int   rdy_mode;
    int   mx, my;
    bit   prev_vld = 1'b0;
    logic force_vld;
    logic rsp_vld;
    logic [SW-1:0] rsp_cost;
    logic [SW-1:0] tbl[16];
    logic [SW-1:0] tbl4[16];
    logic          pv[8];
    logic [SW-1:0] pc[8];
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    assign sad_vld   = rsp_vld | force_vld;
    assign sad_cost  = rsp_cost;
    assign sad_vld4  = sad_req4;
    assign sad_cost4 = tbl4[sad_disp4];
    assign disp_rdy4 = 1'b1;

    sad_disp_sched u_dut (
        .clk(clk), .rst(rst),
        .pix_vld(pix_vld), .pix_rdy(pix_rdy),
        .sad_req(sad_req), .sad_disp(sad_disp),
        .sad_vld(sad_vld), .sad_cost(sad_cost),
        .disp_vld(disp_vld), .disp_rdy(disp_rdy),
        .disp(disp), .disp_cost(disp_cost),
        .disp_x(disp_x), .disp_y(disp_y),
        .frame_done(frame_done), .err(err)
    );

    sad_disp_sched #(.MAX_DISP(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .pix_vld(pix_vld4), .pix_rdy(pix_rdy4),
        .sad_req(sad_req4), .sad_disp(sad_disp4),
        .sad_vld(sad_vld4), .sad_cost(sad_cost4),
        .disp_vld(disp_vld4), .disp_rdy(disp_rdy4),
        .disp(disp4), .disp_cost(disp_cost4),
        .disp_x(disp_x4), .disp_y(disp_y4),
        .frame_done(frame_done4), .err(err4)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SAD unit model: fixed latency 'lat', cost looked up by disparity.
    initial begin
        rsp_vld  = 1'b0;
        rsp_cost = '0;
        req_cnt  = 0;
        for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pc[i] = '0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 7; i++) begin pv[i] = pv[i+1]; pc[i] = pc[i+1]; end
            pv[7] = 1'b0;
            pc[7] = '0;
            if (rst) begin
                for (int i = 0; i < 8; i++) pv[i] = 1'b0;
            end else if (sad_req) begin
                chk("sad_disp_order", int'(sad_disp), req_cnt);
                req_cnt++;
                pv[lat] = 1'b1;
                pc[lat] = tbl[sad_disp];
            end
            rsp_vld  = pv[0];
            rsp_cost = pc[0];
        end
    end

    // Monitor: drives disp_rdy, pops the scoreboard on every handoff.
    initial begin
        exp_t e;
        disp_rdy = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       disp_rdy = ($urandom_range(0, 9) < 7);
                1:       disp_rdy = 1'b0;
                default: disp_rdy = 1'b1;
            endcase
            #1;
            if (frame_done) fd_cnt++;
            if (disp_vld && !prev_vld) begin
                if (sbq.size() == 0) chk("unexpected_result", int'(disp_vld), 0);
                else chk("latency", cyc - sbq[0].t_acc, sbq[0].n + sbq[0].lat);
            end
            if (disp_vld && disp_rdy && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("disp",       int'(disp),       e.disp);
                chk("disp_cost",  int'(disp_cost),  e.cost);
                chk("disp_x",     int'(disp_x),     e.x);
                chk("disp_y",     int'(disp_y),     e.y);
                chk("frame_done", int'(frame_done), int'(e.last));
                chk("req_count",  req_cnt,          e.n);
                req_cnt = 0;
            end else if (disp_vld) begin
                chk("frame_done_hold", int'(frame_done), 0);
            end
            prev_vld = disp_vld;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pix_rdy"},    int'(pix_rdy),    1);
        chk({tag, "_sad_req"},    int'(sad_req),    0);
        chk({tag, "_sad_disp"},   int'(sad_disp),   0);
        chk({tag, "_disp_vld"},   int'(disp_vld),   0);
        chk({tag, "_disp"},       int'(disp),       0);
        chk({tag, "_disp_cost"},  int'(disp_cost),  0);
        chk({tag, "_disp_x"},     int'(disp_x),     0);
        chk({tag, "_disp_y"},     int'(disp_y),     0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_err"},        int'(err),        0);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (!pix_rdy && g < 500) begin @(negedge clk); g++; end
        chk("idle_wait", int'(pix_rdy), 1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sbq.size() > 0 && g < 2000) begin @(negedge clk); g++; end
        chk("drain_wait", sbq.size(), 0);
    endtask

    // Reference: N candidates bounded by column and MAX_DISP, first minimum wins.
    task automatic issue_pixel();
        exp_t e;
        int   bi;
        e.n = ((mx < 15) ? mx : 15) + 1;
        bi  = 0;
        for (int i = 1; i < e.n; i++) if (tbl[i] < tbl[bi]) bi = i;
        e.disp  = bi;
        e.cost  = int'(tbl[bi]);
        e.x     = mx;
        e.y     = my;
        e.t_acc = cyc + 1;
        e.lat   = lat;
        e.last  = (mx == 7) && (my == 7);
        sbq.push_back(e);
        mx++;
        if (mx == 8) begin
            mx = 0;
            my = (my == 7) ? 0 : my + 1;
        end
        pix_vld = 1'b1;
        @(negedge clk);
        pix_vld = 1'b0;
    endtask

    task automatic backpressure_check();
        int g = 0;
        int snap;
        while (!disp_vld && g < 200) begin @(negedge clk); g++; end
        chk("bp_wait", int'(disp_vld), 1);
        snap = int'({disp, disp_cost, disp_x, disp_y});
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("bp_disp_vld", int'(disp_vld), 1);
            chk("bp_pix_rdy",  int'(pix_rdy),  0);
            chk("bp_sad_req",  int'(sad_req),  0);
            chk("bp_stable",   int'({disp, disp_cost, disp_x, disp_y}), snap);
        end
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("bp_release_pix_rdy",  int'(pix_rdy),  1);
        chk("bp_release_disp_vld", int'(disp_vld), 0);
        rdy_mode = 0;
    endtask

    task automatic run_dut4();
        int n, bi, cnt, g;
        for (int px = 0; px < 8; px++) begin
            g = 0;
            @(negedge clk);
            while (!pix_rdy4 && g < 100) begin @(negedge clk); g++; end
            chk("d4_idle", int'(pix_rdy4), 1);
            for (int i = 0; i < 16; i++) tbl4[i] = (i < 4) ? 10'($urandom_range(1, 40)) : 10'd0;
            if (px == 7) begin
                tbl4[0] = 10'd8; tbl4[1] = 10'd6; tbl4[2] = 10'd5; tbl4[3] = 10'd2;
            end
            n  = ((px < 3) ? px : 3) + 1;
            bi = 0;
            for (int i = 1; i < n; i++) if (tbl4[i] < tbl4[bi]) bi = i;
            pix_vld4 = 1'b1;
            @(negedge clk);
            pix_vld4 = 1'b0;
            cnt = 0;
            g   = 0;
            while (!disp_vld4 && g < 100) begin
                cnt += int'(sad_req4);
                @(negedge clk);
                g++;
            end
            chk("d4_result_wait", int'(disp_vld4),  1);
            chk("d4_disp",        int'(disp4),      bi);
            chk("d4_disp_cost",   int'(disp_cost4), int'(tbl4[bi]));
            chk("d4_disp_x",      int'(disp_x4),    px);
            chk("d4_req_count",   cnt,              n);
        end
    endtask

    initial begin
        int hi;
        rst       = 1'b1;
        pix_vld   = 1'b0;
        pix_vld4  = 1'b0;
        force_vld = 1'b0;
        rdy_mode  = 0;
        lat       = 0;
        mx        = 0;
        my        = 0;
        for (int i = 0; i < 16; i++) begin tbl[i] = '0; tbl4[i] = '0; end
        repeat (3) @(negedge clk);
        #2;
        check_reset_vals("rst");
        rst = 1'b0;

        // Full frame plus one pixel to observe the wrap to (0,0).
        for (int p = 0; p < 65; p++) begin
            wait_idle();
            hi = (p % 2 == 1) ? 15 : 1023;
            for (int i = 0; i < 16; i++) tbl[i] = 10'($urandom_range(0, hi));
            lat = $urandom_range(0, 4);
            if (p == 0) begin
                tbl[0] = 10'd37;
                lat = 2;
            end
            if (p == 5) begin
                tbl[0] = 10'd9;  tbl[1] = 10'd4;  tbl[2] = 10'd7;
                tbl[3] = 10'd4;  tbl[4] = 10'd12; tbl[5] = 10'd30;
                lat = 3;
            end
            if (p == 10) rdy_mode = 1;
            issue_pixel();
            if (p == 10) backpressure_check();
            if (p == 63) begin
                wait_drain();
                chk("frame_done_count", fd_cnt, 1);
            end
        end
        wait_drain();
        chk("err_clean", int'(err), 0);

        // Spurious SAD result while idle.
        @(negedge clk);
        #2 force_vld = 1'b1;
        @(negedge clk);
        #2 force_vld = 1'b0;
        chk("err_set", int'(err), 1);
        repeat (3) @(negedge clk);
        #2 chk("err_sticky", int'(err), 1);

        // Reset in the middle of ISSUE (pixel at x=1, two requests).
        wait_idle();
        lat = 2;
        pix_vld = 1'b1;
        @(negedge clk);
        pix_vld = 1'b0;
        #2;
        chk("mid_issue_sad_req", int'(sad_req), 1);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check_reset_vals("mid_rst");
        rst     = 1'b0;
        req_cnt = 0;
        mx      = 0;
        my      = 0;

        wait_idle();
        for (int i = 0; i < 16; i++) tbl[i] = 10'($urandom_range(0, 1023));
        lat = 1;
        issue_pixel();
        wait_drain();

        run_dut4();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
